// File: rtl/alu_issue_pkg.sv
// alu_pkg: shared definitions for the alu_issue front end.
//   - ALU command encodings (what the downstream ALU understands)
//   - request opcode encodings (what the sequencer sends)
//   - FSM state encoding for alu_issue
package alu_pkg;

    // ALU command encodings
    localparam logic [2:0] AND_CMD = 3'd0;
    localparam logic [2:0] OR_CMD  = 3'd1;
    localparam logic [2:0] XOR_CMD = 3'd2;
    localparam logic [2:0] SLT_CMD = 3'd3;
    localparam logic [2:0] ADD_CMD = 3'd4;
    localparam logic [2:0] SUB_CMD = 3'd5;

    // Request opcode encodings; 7..15 are illegal
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: request/response channels between the instruction sequencer
// (master) and alu_issue (slave).
//   req_valid/req_ready/req_op/req_a/req_b/req_tag : request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_tag/rsp_err  : response channel
//   req_fwd_a : only present when ALU_ISSUE_FWD_EN is defined
interface alu_issue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_op;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic [TAG_WIDTH-1:0]  req_tag;
`ifdef ALU_ISSUE_FWD_EN
    logic                  req_fwd_a;
`endif
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [TAG_WIDTH-1:0]  rsp_tag;
    logic                  rsp_err;

    modport master (
`ifdef ALU_ISSUE_FWD_EN
        output req_fwd_a,
`endif
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
`ifdef ALU_ISSUE_FWD_EN
        input  req_fwd_a,
`endif
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );
endinterface

// File: rtl/alu_issue_op_decode.sv
// alu_op_decode: combinational request-opcode decoder.
//   op      in  : request opcode (0..6 legal)
//   cmd     out : ALU command
//   sign    out : ALU sign select (only set for signed SLT)
//   illegal out : opcode outside 0..6
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int CMD_WIDTH = 3
) (
    input  logic [3:0]           op,
    output logic [CMD_WIDTH-1:0] cmd,
    output logic                 sign,
    output logic                 illegal
);

    // Opcode to {cmd, sign, illegal}; illegal codes leave cmd/sign at zero
    always_comb begin
        cmd     = '0;
        sign    = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_AND:  cmd = CMD_WIDTH'(AND_CMD);
            OP_OR:   cmd = CMD_WIDTH'(OR_CMD);
            OP_XOR:  cmd = CMD_WIDTH'(XOR_CMD);
            OP_SLT: begin
                cmd  = CMD_WIDTH'(SLT_CMD);
                sign = 1'b1;
            end
            OP_SLTU: cmd = CMD_WIDTH'(SLT_CMD);
            OP_ADD:  cmd = CMD_WIDTH'(ADD_CMD);
            OP_SUB:  cmd = CMD_WIDTH'(SUB_CMD);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: initiator-side front end for a registered ALU.
// Accepts a request, decodes it, holds operands/command stable for the ALU,
// captures the registered ALU result and returns it with the request tag.
//   clk, rst         : clock, asynchronous active-high reset
//   bus (slave)      : request/response channels (see alu_issue_if)
//   alu_in1/alu_in2  : operands to the ALU
//   alu_sign/alu_cmd : sign select and command to the ALU
//   alu_out          : registered ALU result
// Optional feature macro: ALU_ISSUE_FWD_EN adds req_fwd_a and a last-result
// register so operand A can be taken from the previous legal result.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CMD_WIDTH  = 3,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_issue_if.slave            bus,
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    output logic                  alu_sign,
    output logic [CMD_WIDTH-1:0]  alu_cmd,
    input  logic [DATA_WIDTH-1:0] alu_out
);

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] alu_in1_q, alu_in1_d;
    logic [DATA_WIDTH-1:0] alu_in2_q, alu_in2_d;
    logic [CMD_WIDTH-1:0]  alu_cmd_q, alu_cmd_d;
    logic                  alu_sign_q, alu_sign_d;

    logic [CMD_WIDTH-1:0]  dec_cmd_s;
    logic                  dec_sign_s;
    logic                  dec_illegal_s;
    logic [DATA_WIDTH-1:0] opa_s;

    alu_op_decode #(
        .CMD_WIDTH (CMD_WIDTH)
    ) u_decode (
        .op      (bus.req_op),
        .cmd     (dec_cmd_s),
        .sign    (dec_sign_s),
        .illegal (dec_illegal_s)
    );

`ifdef ALU_ISSUE_FWD_EN
    logic [DATA_WIDTH-1:0] last_q, last_d;

    assign opa_s = bus.req_fwd_a ? last_q : bus.req_a;

    // Last legal result: refreshed on every capture
    always_comb begin
        if (state_q == ST_CAPT) begin
            last_d = alu_out;
        end else begin
            last_d = last_q;
        end
    end

    // Last-result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign opa_s = bus.req_a;
`endif

    // Next-state and next-output logic; registers hold unless a state acts
    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_err_d  = rsp_err_q;
        alu_in1_d  = alu_in1_q;
        alu_in2_d  = alu_in2_q;
        alu_cmd_d  = alu_cmd_q;
        alu_sign_d = alu_sign_q;
        case (state_q)
            ST_IDLE: begin
                // req_ready_q is low in the first cycle out of reset
                if (bus.req_valid && req_ready_q) begin
                    rsp_tag_d = bus.req_tag;
                    if (dec_illegal_s) begin
                        // ALU-facing registers are deliberately untouched
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = ST_RESP;
                    end else begin
                        alu_in1_d  = opa_s;
                        alu_in2_d  = bus.req_b;
                        alu_cmd_d  = dec_cmd_s;
                        alu_sign_d = dec_sign_s;
                        state_d    = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                rsp_data_d = alu_out;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake outputs are registered copies of the upcoming state, so a
        // completing response always leaves one idle cycle before the next accept
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_cmd_q   <= '0;
            alu_sign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            alu_cmd_q   <= alu_cmd_d;
            alu_sign_q  <= alu_sign_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_err   = rsp_err_q;
    assign alu_in1       = alu_in1_q;
    assign alu_in2       = alu_in2_q;
    assign alu_cmd       = alu_cmd_q;
    assign alu_sign      = alu_sign_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a behavioural registered ALU.
// Define ALU_ISSUE_FWD_EN for both RTL and bench to exercise forwarding.
module tb_alu_issue;

    localparam int DW = 32;
    localparam int TW = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] alu_in1;
    logic [DW-1:0] alu_in2;
    logic          alu_sign;
    logic [2:0]    alu_cmd;
    logic [DW-1:0] alu_out;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    // Bench's own view of what the ALU-facing outputs should be holding
    logic [DW-1:0] exp_in1  = '0;
    logic [DW-1:0] exp_in2  = '0;
    logic [2:0]    exp_cmd  = 3'd0;
    logic          exp_sign = 1'b0;
    logic [DW-1:0] last_res = '0;

    alu_issue_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    alu_issue #(
        .DATA_WIDTH (DW),
        .CMD_WIDTH  (3),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_sign (alu_sign),
        .alu_cmd  (alu_cmd),
        .alu_out  (alu_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_beh(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [2:0] cmd, input logic sgn);
        case (cmd)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return sgn ? {31'd0, ($signed(a) < $signed(b))} : {31'd0, (a < b)};
            3'd4:    return a + b;
            3'd5:    return a - b;
            default: return '0;
        endcase
    endfunction

    // Registered ALU stand-in: samples operands on every rising edge
    always_ff @(posedge clk) begin
        alu_out <= alu_beh(alu_in1, alu_in2, alu_cmd, alu_sign);
    end

    // Expected result straight from the request opcode
    function automatic logic [DW-1:0] exp_result(input logic [3:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a + b;
            4'd6:    return a - b;
            default: return '0;
        endcase
    endfunction

    // Expected {cmd, sign} for a legal opcode
    function automatic logic [3:0] exp_dec(input logic [3:0] op);
        case (op)
            4'd0:    return {3'd0, 1'b0};
            4'd1:    return {3'd1, 1'b0};
            4'd2:    return {3'd2, 1'b0};
            4'd3:    return {3'd3, 1'b1};
            4'd4:    return {3'd3, 1'b0};
            4'd5:    return {3'd4, 1'b0};
            4'd6:    return {3'd5, 1'b0};
            default: return 4'd0;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request; returns at the first falling edge after the accept edge
    task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TW-1:0] tag, input logic fwd);
        int            waited;
        logic [DW-1:0] opa;
        logic [3:0]    d;
        exp_t          e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
`ifdef ALU_ISSUE_FWD_EN
        bus.req_fwd_a = fwd;
`endif
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("accept_wait", 64'(waited < 50), 64'd1);
        @(posedge clk);
        opa = fwd ? last_res : a;
        e.tag = tag;
        if (op <= 4'd6) begin
            e.data   = exp_result(op, opa, b);
            e.err    = 1'b0;
            d        = exp_dec(op);
            exp_cmd  = d[3:1];
            exp_sign = d[0];
            exp_in1  = opa;
            exp_in2  = b;
            last_res = e.data;
        end else begin
            e.data = '0;
            e.err  = 1'b1;
        end
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_eq("alu_in1", 64'(alu_in1), 64'(exp_in1));
        check_eq("alu_in2", 64'(alu_in2), 64'(exp_in2));
        check_eq("alu_cmd", 64'(alu_cmd), 64'(exp_cmd));
        check_eq("alu_sign", 64'(alu_sign), 64'(exp_sign));
    endtask

    // Wait for the response, compare against the scoreboard, optionally stall
    // it for 'hold' cycles, then complete the handshake
    task automatic collect(input int hold);
        int   lat;
        exp_t e;
        // lat counts rising edges after the accept edge: legal ops respond
        // after E2, illegal ops right after the accept edge itself
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("latency", 64'(lat), e.err ? 64'd0 : 64'd2);
            check_eq("rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check_eq("rsp_data", 64'(bus.rsp_data), 64'(e.data));
            check_eq("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
            check_eq("rsp_err", 64'(bus.rsp_err), 64'(e.err));
            check_eq("req_ready_resp", 64'(bus.req_ready), 64'd0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq("hold_valid", 64'(bus.rsp_valid), 64'd1);
                check_eq("hold_data", 64'(bus.rsp_data), 64'(e.data));
                check_eq("hold_tag", 64'(bus.rsp_tag), 64'(e.tag));
                check_eq("hold_ready", 64'(bus.req_ready), 64'd0);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_eq("rsp_done_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rsp_done_ready", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
        bus.req_fwd_a = 1'b0;
`endif
        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check_eq("rst_alu_cmd", 64'(alu_cmd), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 64'(bus.req_ready), 64'd1);

        // ADD wraps to zero
        send(4'd5, 32'hFFFF_FFFF, 32'd1, 4'd3, 1'b0);
        collect(0);
        // Signed vs unsigned compare on the same operands
        send(4'd3, 32'h8000_0000, 32'd1, 4'd1, 1'b0);
        collect(0);
        send(4'd4, 32'h8000_0000, 32'd1, 4'd2, 1'b0);
        collect(0);
        // Illegal opcode: ALU outputs must stay as the SLTU left them
        send(4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 4'd7, 1'b0);
        collect(0);
        // SUB under backpressure
        send(4'd6, 32'd5, 32'd7, 4'd4, 1'b0);
        collect(5);
        // Mixed random traffic, including illegal opcodes
        for (int i = 0; i < 12; i++) begin
            send(4'($urandom_range(0, 9)), $urandom(), $urandom(), 4'($urandom_range(0, 15)), 1'b0);
            collect(int'($urandom_range(0, 2)));
        end
`ifdef ALU_ISSUE_FWD_EN
        // Chained ADD through the last-result register: (2+3)+10
        send(4'd5, 32'd2, 32'd3, 4'd8, 1'b0);
        collect(0);
        send(4'd5, 32'hDEAD_BEEF, 32'd10, 4'd9, 1'b1);
        collect(0);
`endif
        // Reset while a SUB is in EXEC: request dropped, everything cleared
        send(4'd6, 32'd20, 32'd3, 4'd5, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("mid_rst_cmd", 64'(alu_cmd), 64'd0);
        check_eq("mid_rst_in1", 64'(alu_in1), 64'd0);
        sb.delete();
        exp_in1  = '0;
        exp_in2  = '0;
        exp_cmd  = 3'd0;
        exp_sign = 1'b0;
        last_res = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ready", 64'(bus.req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("mid_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        // Still functional afterwards
        send(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6, 1'b0);
        collect(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
